// File: rtl/mux_n_reg_pkg.sv
// Shared constants and helpers for the registered N-input multiplexer.
package mux_pkg;

    localparam int MUX_BIN    = 0;
    localparam int MUX_ONEHOT = 1;

    // Select width for binary encoding; never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when exactly one bit is set. Callers zero-extend narrower selects.
    function automatic logic onehot_legal(input logic [15:0] vec);
        return (vec != 16'd0) && ((vec & (vec - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way select with legality check; illegal selects give zeros.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N      = 4,
    parameter int ONEHOT = MUX_BIN,
    parameter int SEL_W  = (ONEHOT == MUX_ONEHOT) ? N : clog2_min1(N)
) (
    input  logic [N*WIDTH-1:0] e,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   d,
    output logic               illegal
);

    logic [N-1:0] hit;

    if (ONEHOT == MUX_ONEHOT) begin : g_onehot
        logic legal;
        assign legal   = onehot_legal(16'(sel));
        assign illegal = ~legal;
        assign hit     = sel & {N{legal}};
    end else begin : g_bin
        assign illegal = ~(int'(sel) < N);
        for (genvar i = 0; i < N; i++) begin : g_hit
            assign hit[i] = (sel == SEL_W'(i));
        end
    end

    // OR-reduce the hit inputs; no hit (illegal select) leaves zeros.
    always_comb begin
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (hit[i]) d = d | e[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-input mux stage with stall, flush, valid tracking and error flags.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               N         = 4,
    parameter int               ONEHOT    = MUX_BIN,
    parameter int               SEL_W     = (ONEHOT == MUX_ONEHOT) ? N : clog2_min1(N),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [N*WIDTH-1:0] e,
    input  logic [SEL_W-1:0]   sel,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   sal,
    output logic               valid_out,
    output logic               sel_err,
    output logic               err_sticky
);

    if (N < 2 || N > 16) begin : g_bad_n
        $fatal(1, "mux_n_reg: N must be in 2..16");
    end

    logic [WIDTH-1:0] d;
    logic             illegal;
    logic             err_nxt;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .ONEHOT(ONEHOT),
        .SEL_W (SEL_W)
    ) u_comb (
        .e      (e),
        .sel    (sel),
        .d      (d),
        .illegal(illegal)
    );

    // An error is only raised by a real capture of qualified data.
    assign err_nxt = ~flush & en & valid_in & illegal;

    // Pipeline register: rst > flush > stall > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sal       <= RESET_VAL;
            valid_out <= 1'b0;
            sel_err   <= 1'b0;
        end else if (flush) begin
            sal       <= RESET_VAL;
            valid_out <= 1'b0;
            sel_err   <= 1'b0;
        end else if (en) begin
            sal       <= d;
            valid_out <= valid_in;
            sel_err   <= err_nxt;
        end else begin
            sel_err   <= 1'b0;
        end
    end

    // Sticky error: a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) err_sticky <= 1'b0;
        else     err_sticky <= err_nxt | (err_sticky & ~err_clr);
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: binary N=4, binary N=3 and one-hot N=4 instances.
module tb_mux_n_reg;

    logic clk = 1'b0;
    logic rst, en, flush, valid_in, err_clr;

    // A: WIDTH=32 N=4 binary
    logic [127:0] e_a;
    logic [1:0]   sel_a;
    logic [31:0]  sal_a;
    logic         vo_a, se_a, st_a;
    // B: WIDTH=8 N=3 binary
    logic [23:0]  e_b;
    logic [1:0]   sel_b;
    logic [7:0]   sal_b;
    logic         vo_b, se_b, st_b;
    // C: WIDTH=8 N=4 one-hot
    logic [31:0]  e_c;
    logic [3:0]   sel_c;
    logic [7:0]   sal_c;
    logic         vo_c, se_c, st_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_n_reg #(.WIDTH(32), .N(4), .ONEHOT(0), .RESET_VAL(32'hDEADBEEF)) u_a (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
        .e(e_a), .sel(sel_a), .err_clr(err_clr),
        .sal(sal_a), .valid_out(vo_a), .sel_err(se_a), .err_sticky(st_a));

    mux_n_reg #(.WIDTH(8), .N(3), .ONEHOT(0), .RESET_VAL(8'hA5)) u_b (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
        .e(e_b), .sel(sel_b), .err_clr(err_clr),
        .sal(sal_b), .valid_out(vo_b), .sel_err(se_b), .err_sticky(st_b));

    mux_n_reg #(.WIDTH(8), .N(4), .ONEHOT(1), .RESET_VAL(8'h00)) u_c (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
        .e(e_c), .sel(sel_c), .err_clr(err_clr),
        .sal(sal_c), .valid_out(vo_c), .sel_err(se_c), .err_sticky(st_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_a [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; valid_in = 1'b0; err_clr = 1'b0;
        e_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        e_b = {8'h33, 8'h22, 8'h11};
        e_c = {8'h44, 8'h33, 8'h22, 8'h11};
        sel_a = 2'd0; sel_b = 2'd0; sel_c = 4'b0001;
        tick();
        chk("rst_sal_a", sal_a, 32'hDEADBEEF);
        chk("rst_vo_a", vo_a, 0);
        chk("rst_se_a", se_a, 0);
        chk("rst_st_a", st_a, 0);
        rst = 1'b0;

        // binary sweep
        en = 1'b1; valid_in = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            tick();
            chk($sformatf("sweep_sal%0d", s), sal_a, exp_a[s]);
            chk($sformatf("sweep_vo%0d", s), vo_a, 1);
            chk($sformatf("sweep_se%0d", s), se_a, 0);
        end

        // stall
        sel_a = 2'd2; tick();
        chk("stall_cap", sal_a, 32'h33333333);
        en = 1'b0; sel_a = 2'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_sal%0d", c), sal_a, 32'h33333333);
            chk($sformatf("stall_vo%0d", c), vo_a, 1);
        end
        en = 1'b1; tick();
        chk("stall_resume", sal_a, 32'h22222222);

        // flush over stall
        flush = 1'b1; en = 1'b0; tick();
        chk("flush_sal", sal_a, 32'hDEADBEEF);
        chk("flush_vo", vo_a, 0);
        flush = 1'b0; en = 1'b1;

        // illegal binary select on N=3
        sel_b = 2'd3; valid_in = 1'b1; tick();
        chk("ill_sal", sal_b, 0);
        chk("ill_se", se_b, 1);
        chk("ill_st", st_b, 1);
        sel_b = 2'd1; tick();
        chk("ill_se_drop", se_b, 0);
        chk("ill_st_hold", st_b, 1);
        chk("leg_sal", sal_b, 8'h22);
        tick();
        chk("ill_st_hold2", st_b, 1);
        valid_in = 1'b0; sel_b = 2'd3; tick();
        chk("ill_novld_se", se_b, 0);
        chk("ill_novld_sal", sal_b, 0);
        chk("ill_novld_vo", vo_b, 0);

        // rst beats flush and illegal capture
        rst = 1'b1; flush = 1'b1; valid_in = 1'b1; tick();
        chk("rstpri_sal", sal_b, 8'hA5);
        chk("rstpri_vo", vo_b, 0);
        chk("rstpri_se", se_b, 0);
        chk("rstpri_st", st_b, 0);
        rst = 1'b0; flush = 1'b0;

        // sel_err is one cycle even while stalled
        sel_b = 2'd3; tick();
        chk("pulse_se", se_b, 1);
        en = 1'b0; tick();
        chk("pulse_se_st0", se_b, 0);
        tick();
        chk("pulse_se_st1", se_b, 0);
        chk("pulse_st", st_b, 1);
        en = 1'b1;

        // err_clr alone, then against a new error
        sel_b = 2'd0; err_clr = 1'b1; tick();
        chk("clr_st", st_b, 0);
        chk("clr_se", se_b, 0);
        sel_b = 2'd3; tick();
        chk("clr_win_st", st_b, 1);
        chk("clr_win_se", se_b, 1);
        sel_b = 2'd0; tick();
        chk("clr_again_st", st_b, 0);
        err_clr = 1'b0;

        // one-hot
        rst = 1'b1; tick(); rst = 1'b0;
        sel_c = 4'b0100; tick();
        chk("oh_sal", sal_c, 8'h33);
        chk("oh_se", se_c, 0);
        chk("oh_st", st_c, 0);
        sel_c = 4'b0000; tick();
        chk("oh_zero_sal", sal_c, 0);
        chk("oh_zero_se", se_c, 1);
        sel_c = 4'b0110; tick();
        chk("oh_two_sal", sal_c, 0);
        chk("oh_two_se", se_c, 1);
        sel_c = 4'b1000; tick();
        chk("oh_leg_sal", sal_c, 8'h44);
        chk("oh_leg_se", se_c, 0);
        chk("oh_leg_st", st_c, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised N-input, WIDTH-bit registered multiplexer stage. It replaces the fixed 32-bit two-input combinational selector wherever a pipelined datapath needs operand selection, for example ALU operand, writeback and forwarding selects. It supports binary or one-hot select encoding, stall (enable) and flush (bubble) controls, and a valid bit that travels with the data. Illegal selects are detected and recorded in a sticky error flag.

## Interface
Parameters:
- WIDTH, 32, data width per input
- N, 4, number of inputs (2..16)
- ONEHOT, 0, 0 = binary select, 1 = one-hot select
- SEL_W, ONEHOT ? N : $clog2(N), select width (derived; do not override)
- RESET_VAL, 0, value of `sal` after reset and flush

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  1 = capture, 0 = hold (stall)
- flush  in  1  insert bubble
- valid_in  in  1  input data qualifier
- e  in  N*WIDTH  flattened inputs; input i = e[i*WIDTH +: WIDTH]
- sel  in  SEL_W  select
- err_clr  in  1  clears sticky error
- sal  out  WIDTH  registered selected data
- valid_out  out  1  registered qualifier
- sel_err  out  1  one-cycle pulse: an illegal select was captured
- err_sticky  out  1  set by any illegal capture; held until cleared

## Operation
- Legal select:
  - Binary mode: `sel < N`.
  - One-hot mode: exactly one bit of `sel` set.
- Illegal select:
  - Binary mode: `sel >= N`. This is only possible when N is not a power of two.
  - One-hot mode: `sel` is zero or has more than one bit set.
- Combinational pick `d`: input[sel] when legal, otherwise all-zeros.
- Per-edge update priority (highest first):
  1. rst: `sal`=RESET_VAL, `valid_out`=0, `sel_err`=0, `err_sticky`=0.
  2. flush: `sal`=RESET_VAL, `valid_out`=0, `sel_err`=0. `err_sticky` is unchanged apart from err_clr. Flush wins over `en`=0.
  3. en=0: `sal` and `valid_out` hold; `sel_err`=0; no error detection.
  4. en=1: `sal`=d, `valid_out`=valid_in, `sel_err`=valid_in & illegal.
- Errors are only flagged when valid_in=1. An illegal select with valid_in=0 still drives zeros but raises no error.
- err_sticky:
  - Next value = (err_sticky | (sel_err next value)) & ~err_clr_effective.
  - err_clr and a new error in the same cycle: the error wins, so `err_sticky`=1.
- `sal` is not gated by `valid_out`. Consumers must qualify with `valid_out`.

## Timing
- Latency: 1 cycle from capture edge to `sal`/`valid_out`/`sel_err`.
- Throughput: one capture per cycle while en=1.
- Reset values: `sal`=RESET_VAL, `valid_out`=0, `sel_err`=0, `err_sticky`=0. All take effect on the first edge with rst=1.
- Reset mid-stall: reset overrides the hold; outputs return to reset values.
- Stall:
  - `sal` and `valid_out` remain stable for every cycle en=0.
  - `sel_err` drops to 0 after one cycle even if the stall continues.
- Inputs `e`, `sel`, `valid_in` are sampled only on edges with en=1 and no flush/rst.
- No combinational path from any input to any output.

## Structure
- Package `mux_pkg` holds:
  - mode constants `MUX_BIN=0`, `MUX_ONEHOT=1`
  - function `onehot_legal(vec)`
  - function `clog2_min1` (N=2 gives SEL_W=1)
- Sub-module `mux_n_comb` holds the parametrised combinational select and legality check: WIDTH, N, ONEHOT in; `d` and `illegal` out.
- `mux_n_reg` adds the pipeline register, priority logic and error flags.
- Elaboration check: N<2 or N>16 is a fatal error.

## Test plan
- Basic binary select: WIDTH=32, N=4, en=1, valid_in=1; inputs e0..e3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel sweeps 0..3 on successive cycles. Required: `sal` follows the sweep one cycle later (0x11111111, 0x22222222, 0x33333333, 0x44444444); `valid_out`=1; `sel_err`=0.
- Stall: capture sel=2 (`sal`=0x33333333), then en=0 for 3 cycles while sel=1. Required: `sal` stays 0x33333333 and `valid_out` stays 1 for all 3 cycles; after en returns to 1, `sal`=0x22222222 one cycle later.
- Flush and reset priority:
  - flush=1 together with en=0. Required: `sal`=RESET_VAL and `valid_out`=0 next cycle.
  - rst=1 together with flush=1 and an illegal select. Required: all outputs at reset values, including `err_sticky`=0.
- Illegal binary select: N=3, sel=3, valid_in=1. Required: `sal`=0, `sel_err` pulses for exactly 1 cycle, `err_sticky`=1 and held. Repeat with valid_in=0. Required: no new `sel_err`.
- One-hot mode: ONEHOT=1, N=4.
  - sel=4'b0100. Required: `sal`=e2, no error.
  - sel=4'b0000, then 4'b0110. Required: `sal`=0 and a `sel_err` pulse on each.
- err_clr:
  - Pulse err_clr alone. Required: `err_sticky`=0 next cycle.
  - err_clr in the same cycle as a new illegal capture. Required: `err_sticky`=1.
